usbf_ssram_arb: RTL

//  Single-port SSRAM arbiter for the USB function core, in the phy_clk domain. Consumes the memory

---
 rtl/usbf_ssram_arb_pkg.sv | 21 ++
 rtl/usbf_ssram_arb.sv | 135 +++++++++++++
 2 files changed

// File: rtl/usbf_ssram_arb_pkg.sv
// ============================================================================
// Module   : usbf_ssram_arb_pkg
// Brief    : Shared types for the USB function SSRAM arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usbf_ssram_arb_pkg;

  localparam int unsigned c_DATA_W = 32;

  // One-hot arbiter state encoding
  typedef enum logic [2:0] {
    ARB_IDLE   = 3'b001,
    ARB_WB_RD  = 3'b010,
    ARB_WB_ACK = 3'b100
  } arb_state_t;

endpackage : usbf_ssram_arb_pkg

`default_nettype wire

// File: rtl/usbf_ssram_arb.sv
// ============================================================================
// Module   : usbf_ssram_arb
// Brief    : Single-port SSRAM arbiter, protocol engine priority with WISHBONE
//            starvation guard, registered WISHBONE read data and ack
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usbf_ssram_arb
  import usbf_ssram_arb_pkg::*;
#(
  parameter int SSRAM_HADR = 14,
  parameter int STARVE_MAX = 15,
  parameter int STARVE_W   = 4
) (
  input  logic                  i_phy_clk,
  input  logic                  i_rst_n,
  // SSRAM
  output logic [SSRAM_HADR:0]   o_sram_adr,
  output logic [c_DATA_W-1:0]   o_sram_dout,
  input  logic [c_DATA_W-1:0]   i_sram_din,
  output logic                  o_sram_re,
  output logic                  o_sram_we,
  // Protocol engine
  input  logic [SSRAM_HADR:0]   i_madr,
  input  logic [c_DATA_W-1:0]   i_mdout,
  output logic [c_DATA_W-1:0]   o_mdin,
  input  logic                  i_mwe,
  input  logic                  i_mreq,
  output logic                  o_mack,
  // WISHBONE side
  input  logic [SSRAM_HADR:0]   i_wadr,
  input  logic [c_DATA_W-1:0]   i_wdin,
  output logic [c_DATA_W-1:0]   o_wdout,
  input  logic                  i_wwe,
  input  logic                  i_wreq,
  output logic                  o_wack
);

  localparam logic [STARVE_W-1:0] c_STARVE_MAX = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] c_STARVE_SAT = {STARVE_W{1'b1}};

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [STARVE_W-1:0]   r_starve_cnt;
  logic                  r_wack;
  logic [c_DATA_W-1:0]   r_wdout;

  logic                  w_idle;
  logic                  w_wb_force;
  logic                  w_pl_gnt;
  logic                  w_wb_gnt;
  logic                  w_wack_nxt;
  logic                  w_wdout_ld;

  assign w_idle     = (r_state == ARB_IDLE);
  assign w_wb_force = w_idle & i_wreq & (r_starve_cnt == c_STARVE_MAX);
  assign w_pl_gnt   = i_mreq & ~w_wb_force;
  assign w_wb_gnt   = i_wreq & ~w_pl_gnt & w_idle;

  // State register
  always_ff @(posedge i_phy_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_wb_gnt) begin
          w_state_nxt = i_wwe ? ARB_WB_ACK : ARB_WB_RD;
        end
      end
      ARB_WB_RD:  w_state_nxt = ARB_WB_ACK;
      ARB_WB_ACK: w_state_nxt = ARB_IDLE;
      default:    w_state_nxt = ARB_IDLE;
    endcase
  end

  // Output logic: SSRAM mux plus next values of the registered WB outputs
  always_comb begin
    o_sram_adr  = i_wadr;
    o_sram_dout = i_wdin;
    o_sram_we   = 1'b0;
    o_sram_re   = 1'b0;
    o_mack      = 1'b0;
    if (w_pl_gnt) begin
      o_sram_adr  = i_madr;
      o_sram_dout = i_mdout;
      o_sram_we   = i_mwe;
      o_sram_re   = ~i_mwe;
      o_mack      = 1'b1;
    end else if (w_wb_gnt) begin
      o_sram_we   = i_wwe;
      o_sram_re   = ~i_wwe;
    end
    w_wack_nxt = (w_wb_gnt & i_wwe) | (r_state == ARB_WB_RD);
    w_wdout_ld = (r_state == ARB_WB_RD);
  end

  always_ff @(posedge i_phy_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wack  <= 1'b0;
      r_wdout <= '0;
    end else begin
      r_wack <= w_wack_nxt;
      if (w_wdout_ld) begin
        r_wdout <= i_sram_din;
      end
    end
  end

  // Counts cycles WB spends blocked behind the protocol engine while idle
  always_ff @(posedge i_phy_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_wb_gnt || !i_wreq) begin
      r_starve_cnt <= '0;
    end else if (w_idle && i_mreq && !w_wb_force && (r_starve_cnt != c_STARVE_SAT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign o_mdin  = i_sram_din;
  assign o_wdout = r_wdout;
  assign o_wack  = r_wack;

endmodule : usbf_ssram_arb

`default_nettype wire
